// File: rtl/vga_pkg.sv
// ============================================================================
// vga_pkg : shared VGA 640x480@60 timing constants, framebuffer geometry,
//           pixel bit positions and colour-channel levels.
// Revision: 1.0
// ============================================================================
`default_nettype none

package vga_pkg;

  // Horizontal timing in pixel ticks
  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  // Vertical timing in lines
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int FB_W     = 320;
  localparam int FB_H     = 240;

  localparam int CNT_W    = 10;
  localparam int ADDR_W   = 17;
  localparam int PIX_W    = 3;

  localparam int PIX_R    = 2;
  localparam int PIX_G    = 1;
  localparam int PIX_B    = 0;

  localparam logic [3:0] CH_ON  = 4'hF;
  localparam logic [3:0] CH_OFF = 4'h0;

  function automatic logic [3:0] chan_level(input logic bit_set);
    return bit_set ? CH_ON : CH_OFF;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_scanout_if.sv
// ============================================================================
// vga_scanout_if : framebuffer read port and VGA pin bundle of vga_scanout.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface vga_scanout_if;
  import vga_pkg::*;

  logic [ADDR_W-1:0] O_FB_ADDR;
  logic [PIX_W-1:0]  I_FB_DATA;
  logic              I_TESTPAT;
  logic              O_HSYNC;
  logic              O_VSYNC;
  logic [3:0]        O_VIDEO_R;
  logic [3:0]        O_VIDEO_G;
  logic [3:0]        O_VIDEO_B;
  logic              O_VBLANK;
  logic              O_FRAME_START;

  modport master (
    output O_FB_ADDR,
    input  I_FB_DATA,
    input  I_TESTPAT,
    output O_HSYNC,
    output O_VSYNC,
    output O_VIDEO_R,
    output O_VIDEO_G,
    output O_VIDEO_B,
    output O_VBLANK,
    output O_FRAME_START
  );

  modport slave (
    input  O_FB_ADDR,
    output I_FB_DATA,
    output I_TESTPAT,
    input  O_HSYNC,
    input  O_VSYNC,
    input  O_VIDEO_R,
    input  O_VIDEO_G,
    input  O_VIDEO_B,
    input  O_VBLANK,
    input  O_FRAME_START
  );

endinterface

`default_nettype wire

// File: rtl/vga_timing.sv
// ============================================================================
// vga_timing : pixel-tick divider, horizontal/vertical scan counters and the
//              raw (undelayed) sync, active and vblank flags.
// Revision: 1.0
// ============================================================================
`default_nettype none

module vga_timing
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int H_ACT    = H_ACTIVE,
  parameter int H_FRONT  = H_FP,
  parameter int H_SYNC_W = H_SYNC,
  parameter int H_BACK   = H_BP,
  parameter int V_ACT    = V_ACTIVE,
  parameter int V_FRONT  = V_FP,
  parameter int V_SYNC_W = V_SYNC,
  parameter int V_BACK   = V_BP
) (
  input  wire logic             clk,
  input  wire logic             rst,
  output logic                  o_tick,
  output logic [CNT_W-1:0]      o_hcnt,
  output logic                  o_hsync_n,
  output logic                  o_vsync_n,
  output logic                  o_active,
  output logic                  o_vblank,
  output logic                  o_row_step,
  output logic                  o_frame_end
);

  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HTOT    = H_ACT + H_FRONT + H_SYNC_W + H_BACK;
  localparam int VTOT    = V_ACT + V_FRONT + V_SYNC_W + V_BACK;
  localparam int HS_BEG  = H_ACT + H_FRONT;
  localparam int HS_END  = H_ACT + H_FRONT + H_SYNC_W - 1;
  localparam int VS_BEG  = V_ACT + V_FRONT;
  localparam int VS_END  = V_ACT + V_FRONT + V_SYNC_W - 1;

  logic [DIV_W-1:0] r_div;
  logic [CNT_W-1:0] r_hcnt;
  logic [CNT_W-1:0] r_vcnt;
  logic             w_tick;
  logic             w_line_end;
  logic             w_last_line;

  assign w_tick      = (r_div == DIV_W'(CLK_DIV - 1));
  assign w_line_end  = w_tick && (r_hcnt == CNT_W'(HTOT - 1));
  assign w_last_line = (r_vcnt == CNT_W'(VTOT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div  <= '0;
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else begin
      r_div <= w_tick ? '0 : r_div + DIV_W'(1);
      if (w_tick) begin
        if (r_hcnt == CNT_W'(HTOT - 1)) begin
          r_hcnt <= '0;
          r_vcnt <= w_last_line ? '0 : r_vcnt + CNT_W'(1);
        end else begin
          r_hcnt <= r_hcnt + CNT_W'(1);
        end
      end
    end
  end

  assign o_tick      = w_tick;
  assign o_hcnt      = r_hcnt;
  assign o_hsync_n   = !((r_hcnt >= CNT_W'(HS_BEG)) && (r_hcnt <= CNT_W'(HS_END)));
  assign o_vsync_n   = !((r_vcnt >= CNT_W'(VS_BEG)) && (r_vcnt <= CNT_W'(VS_END)));
  assign o_active    = (r_hcnt < CNT_W'(H_ACT)) && (r_vcnt < CNT_W'(V_ACT));
  assign o_vblank    = (r_vcnt >= CNT_W'(V_ACT));
  // Framebuffer row advances after every odd line; the frame wrap clears it instead.
  assign o_row_step  = w_line_end && r_vcnt[0] && !w_last_line;
  assign o_frame_end = w_line_end && w_last_line;

endmodule

`default_nettype wire

// File: rtl/vga_scanout.sv
// ============================================================================
// vga_scanout : scans a 320x240x3bpp framebuffer out as pixel-doubled
//               640x480@60 VGA with a 2-tick counter-to-pin pipeline.
// Optional feature macro: VGA_TESTPAT_EN (8 vertical colour bars on I_TESTPAT).
// Revision: 1.0
// ============================================================================
`default_nettype none

module vga_scanout
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int H_ACT    = H_ACTIVE,
  parameter int H_FRONT  = H_FP,
  parameter int H_SYNC_W = H_SYNC,
  parameter int H_BACK   = H_BP,
  parameter int V_ACT    = V_ACTIVE,
  parameter int V_FRONT  = V_FP,
  parameter int V_SYNC_W = V_SYNC,
  parameter int V_BACK   = V_BP,
  parameter int FB_WIDTH = FB_W
) (
  input  wire logic     CLK,
  input  wire logic     I_RESET,
  vga_scanout_if.master bus
);

  logic              w_tick;
  logic [CNT_W-1:0]  w_hcnt;
  logic [CNT_W-1:0]  w_col;
  logic              w_hsync_n;
  logic              w_vsync_n;
  logic              w_active;
  logic              w_vblank;
  logic              w_row_step;
  logic              w_frame_end;
  logic [PIX_W-1:0]  w_pix;

  logic [ADDR_W-1:0] r_row_base;
  logic [ADDR_W-1:0] r_fb_addr;
  logic              r_s0_hsync_n;
  logic              r_s0_vsync_n;
  logic              r_s0_active;
  logic              r_s0_vblank;
  logic              r_hsync_n;
  logic              r_vsync_n;
  logic              r_vblank;
  logic              r_frame_start;
  logic [3:0]        r_video_r;
  logic [3:0]        r_video_g;
  logic [3:0]        r_video_b;

  vga_timing #(
    .CLK_DIV  (CLK_DIV),
    .H_ACT    (H_ACT),
    .H_FRONT  (H_FRONT),
    .H_SYNC_W (H_SYNC_W),
    .H_BACK   (H_BACK),
    .V_ACT    (V_ACT),
    .V_FRONT  (V_FRONT),
    .V_SYNC_W (V_SYNC_W),
    .V_BACK   (V_BACK)
  ) u_timing (
    .clk         (CLK),
    .rst         (I_RESET),
    .o_tick      (w_tick),
    .o_hcnt      (w_hcnt),
    .o_hsync_n   (w_hsync_n),
    .o_vsync_n   (w_vsync_n),
    .o_active    (w_active),
    .o_vblank    (w_vblank),
    .o_row_step  (w_row_step),
    .o_frame_end (w_frame_end)
  );

  assign w_col = w_hcnt >> 1;

  // Stage 0: row base accumulates FB_WIDTH per line pair, so no multiplier is needed.
  always_ff @(posedge CLK) begin
    if (I_RESET) begin
      r_row_base <= '0;
      r_fb_addr  <= '0;
    end else begin
      if (w_frame_end) begin
        r_row_base <= '0;
      end else if (w_row_step) begin
        r_row_base <= r_row_base + ADDR_W'(FB_WIDTH);
      end
      if (w_tick && w_active) begin
        r_fb_addr <= r_row_base + ADDR_W'(w_col);
      end
    end
  end

`ifdef VGA_TESTPAT_EN
  logic             r_s0_tp_sel;
  logic [PIX_W-1:0] r_s0_tp_pix;

  always_ff @(posedge CLK) begin
    if (I_RESET) begin
      r_s0_tp_sel <= 1'b0;
      r_s0_tp_pix <= '0;
    end else if (w_tick) begin
      r_s0_tp_sel <= bus.I_TESTPAT;
      r_s0_tp_pix <= w_hcnt[8:6];
    end
  end

  assign w_pix = r_s0_tp_sel ? r_s0_tp_pix : bus.I_FB_DATA;
`else
  logic w_unused_testpat;
  assign w_unused_testpat = bus.I_TESTPAT;
  assign w_pix            = bus.I_FB_DATA;
`endif

  // Flags ride two ticks alongside the RAM read so syncs line up with the pixel.
  always_ff @(posedge CLK) begin
    if (I_RESET) begin
      r_s0_hsync_n  <= 1'b1;
      r_s0_vsync_n  <= 1'b1;
      r_s0_active   <= 1'b0;
      r_s0_vblank   <= 1'b0;
      r_hsync_n     <= 1'b1;
      r_vsync_n     <= 1'b1;
      r_vblank      <= 1'b0;
      r_video_r     <= CH_OFF;
      r_video_g     <= CH_OFF;
      r_video_b     <= CH_OFF;
      r_frame_start <= 1'b0;
    end else begin
      if (w_tick) begin
        r_s0_hsync_n <= w_hsync_n;
        r_s0_vsync_n <= w_vsync_n;
        r_s0_active  <= w_active;
        r_s0_vblank  <= w_vblank;
        r_hsync_n    <= r_s0_hsync_n;
        r_vsync_n    <= r_s0_vsync_n;
        r_vblank     <= r_s0_vblank;
        r_video_r    <= chan_level(r_s0_active && w_pix[PIX_R]);
        r_video_g    <= chan_level(r_s0_active && w_pix[PIX_G]);
        r_video_b    <= chan_level(r_s0_active && w_pix[PIX_B]);
      end
      // Marks the tick on which the scan counters re-enter the origin.
      r_frame_start <= w_frame_end;
    end
  end

  assign bus.O_FB_ADDR     = r_fb_addr;
  assign bus.O_HSYNC       = r_hsync_n;
  assign bus.O_VSYNC       = r_vsync_n;
  assign bus.O_VIDEO_R     = r_video_r;
  assign bus.O_VIDEO_G     = r_video_g;
  assign bus.O_VIDEO_B     = r_video_b;
  assign bus.O_VBLANK      = r_vblank;
  assign bus.O_FRAME_START = r_frame_start;

endmodule

`default_nettype wire

// File: tb/tb_vga_scanout.sv
// ============================================================================
// tb_vga_scanout : directed checks of vga_scanout at full 640x480 geometry and
//                  at a shrunken 16x8 geometry that completes frames quickly.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_vga_scanout;

  logic clk;
  logic rst;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  int   rel;

  vga_scanout_if bus_f ();
  vga_scanout_if bus_s ();

  vga_scanout u_full (
    .CLK     (clk),
    .I_RESET (rst),
    .bus     (bus_f)
  );

  // Small frame: 24 ticks/line (hsync h=18..21), 12 lines (vsync v=9..10), FB 8 wide
  vga_scanout #(
    .CLK_DIV  (2),
    .H_ACT    (16),
    .H_FRONT  (2),
    .H_SYNC_W (4),
    .H_BACK   (2),
    .V_ACT    (8),
    .V_FRONT  (1),
    .V_SYNC_W (2),
    .V_BACK   (1),
    .FB_WIDTH (8)
  ) u_small (
    .CLK     (clk),
    .I_RESET (rst),
    .bus     (bus_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous RAM models: full DUT mem[a] = a%8, small DUT all 3'b111
  always @(posedge clk) bus_f.I_FB_DATA <= bus_f.O_FB_ADDR[2:0];
  always @(posedge clk) bus_s.I_FB_DATA <= 3'b111;

  initial begin
    #400000;
    $display("FAIL timeout: observed=no-summary expected=finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  function automatic logic [11:0] rgb_f();
    return {bus_f.O_VIDEO_R, bus_f.O_VIDEO_G, bus_f.O_VIDEO_B};
  endfunction

  function automatic logic [11:0] rgb_s();
    return {bus_s.O_VIDEO_R, bus_s.O_VIDEO_G, bus_s.O_VIDEO_B};
  endfunction

  initial begin
    rst             = 1'b1;
    bus_f.I_TESTPAT = 1'b0;
    bus_s.I_TESTPAT = 1'b0;
    repeat (3) @(negedge clk);
    chk("por_hsync", 32'(bus_f.O_HSYNC), 32'd1);
    chk("por_addr",  32'(bus_f.O_FB_ADDR), 32'd0);
    chk("por_rgb",   32'(rgb_f()), 32'h000);
    rst = 1'b0;
    rel = cyc;

    // Output pixel n = h + v*HTOTAL appears after edge 2n+4; its address after edge 2n+2
    wait_to(rel + 4);    chk("f_pix_0_0", 32'(rgb_f()), 32'h000);
                         chk("s_pix_0_0", 32'(rgb_s()), 32'hFFF);
    wait_to(rel + 6);    chk("f_pix_1_0", 32'(rgb_f()), 32'h000);
    wait_to(rel + 8);    chk("f_pix_2_0", 32'(rgb_f()), 32'h00F);
    wait_to(rel + 12);   chk("f_pix_4_0", 32'(rgb_f()), 32'h0F0);
    wait_to(rel + 20);   chk("f_pix_8_0", 32'(rgb_f()), 32'hF00);
    wait_to(rel + 32);   chk("f_pix_14_0", 32'(rgb_f()), 32'hFFF);
    wait_to(rel + 98);   chk("s_addr_line2", 32'(bus_s.O_FB_ADDR), 32'd8);
    wait_to(rel + 368);  chk("s_addr_last", 32'(bus_s.O_FB_ADDR), 32'd31);
    wait_to(rel + 370);  chk("s_pix_15_7", 32'(rgb_s()), 32'hFFF);
    wait_to(rel + 372);  chk("s_pix_16_7", 32'(rgb_s()), 32'h000);
    wait_to(rel + 386);  chk("s_vblank_v7", 32'(bus_s.O_VBLANK), 32'd0);
    wait_to(rel + 388);  chk("s_vblank_v8", 32'(bus_s.O_VBLANK), 32'd1);
                         chk("s_pix_0_8", 32'(rgb_s()), 32'h000);
    wait_to(rel + 434);  chk("s_vsync_v8", 32'(bus_s.O_VSYNC), 32'd1);
    wait_to(rel + 436);  chk("s_vsync_v9", 32'(bus_s.O_VSYNC), 32'd0);
    wait_to(rel + 530);  chk("s_vsync_v10", 32'(bus_s.O_VSYNC), 32'd0);
    wait_to(rel + 532);  chk("s_vsync_v11", 32'(bus_s.O_VSYNC), 32'd1);
    wait_to(rel + 575);  chk("s_fs_before", 32'(bus_s.O_FRAME_START), 32'd0);
    wait_to(rel + 576);  chk("s_fs_pulse", 32'(bus_s.O_FRAME_START), 32'd1);
                         chk("f_fs_quiet", 32'(bus_f.O_FRAME_START), 32'd0);
    wait_to(rel + 577);  chk("s_fs_clear", 32'(bus_s.O_FRAME_START), 32'd0);
    wait_to(rel + 578);  chk("s_addr_frame2", 32'(bus_s.O_FB_ADDR), 32'd0);
                         chk("s_vblank_v11", 32'(bus_s.O_VBLANK), 32'd1);
    wait_to(rel + 580);  chk("s_vblank_f2", 32'(bus_s.O_VBLANK), 32'd0);
    wait_to(rel + 1280); chk("f_addr_639", 32'(bus_f.O_FB_ADDR), 32'd319);
    wait_to(rel + 1282); chk("f_pix_639_0", 32'(rgb_f()), 32'hFFF);
    wait_to(rel + 1284); chk("f_pix_640_0", 32'(rgb_f()), 32'h000);
    wait_to(rel + 1314); chk("f_hs_655", 32'(bus_f.O_HSYNC), 32'd1);
    wait_to(rel + 1316); chk("f_hs_656", 32'(bus_f.O_HSYNC), 32'd0);
    wait_to(rel + 1402); chk("f_addr_hold", 32'(bus_f.O_FB_ADDR), 32'd319);
    wait_to(rel + 1506); chk("f_hs_751", 32'(bus_f.O_HSYNC), 32'd0);
    wait_to(rel + 1508); chk("f_hs_752", 32'(bus_f.O_HSYNC), 32'd1);
    wait_to(rel + 1602); chk("f_addr_line1", 32'(bus_f.O_FB_ADDR), 32'd0);
    wait_to(rel + 2916); chk("f_hs_line1", 32'(bus_f.O_HSYNC), 32'd0);
    wait_to(rel + 3202); chk("f_addr_line2", 32'(bus_f.O_FB_ADDR), 32'd320);
    wait_to(rel + 4520); chk("f_hs_line2", 32'(bus_f.O_HSYNC), 32'd0);
                         chk("f_vsync_hi", 32'(bus_f.O_VSYNC), 32'd1);
                         chk("s_vblank_pre", 32'(bus_s.O_VBLANK), 32'd1);
                         chk("s_vsync_pre", 32'(bus_s.O_VSYNC), 32'd0);

    // Mid-line reset for 3 CLK while full DUT is in hsync and small DUT in vsync
    rst = 1'b1;
    @(negedge clk);
    chk("rst_f_hsync",  32'(bus_f.O_HSYNC), 32'd1);
    chk("rst_f_vsync",  32'(bus_f.O_VSYNC), 32'd1);
    chk("rst_f_addr",   32'(bus_f.O_FB_ADDR), 32'd0);
    chk("rst_f_rgb",    32'(rgb_f()), 32'h000);
    chk("rst_s_vsync",  32'(bus_s.O_VSYNC), 32'd1);
    chk("rst_s_vblank", 32'(bus_s.O_VBLANK), 32'd0);
    chk("rst_s_addr",   32'(bus_s.O_FB_ADDR), 32'd0);
    chk("rst_s_fs",     32'(bus_s.O_FRAME_START), 32'd0);
    repeat (2) @(negedge clk);
    chk("rst_f_hsync3", 32'(bus_f.O_HSYNC), 32'd1);
    rst = 1'b0;
    rel = cyc;
`ifdef VGA_TESTPAT_EN
    bus_f.I_TESTPAT = 1'b1;
`endif

    wait_to(rel + 575);  chk("r_s_fs_before", 32'(bus_s.O_FRAME_START), 32'd0);
    wait_to(rel + 576);  chk("r_s_fs_pulse", 32'(bus_s.O_FRAME_START), 32'd1);
    wait_to(rel + 1314); chk("r_f_hs_655", 32'(bus_f.O_HSYNC), 32'd1);
    wait_to(rel + 1316); chk("r_f_hs_656", 32'(bus_f.O_HSYNC), 32'd0);
    wait_to(rel + 4802); chk("r_f_addr_line3", 32'(bus_f.O_FB_ADDR), 32'd320);
    wait_to(rel + 6402); chk("r_f_addr_line4", 32'(bus_f.O_FB_ADDR), 32'd640);
`ifdef VGA_TESTPAT_EN
    wait_to(rel + 6404); chk("tp_x0",   32'(rgb_f()), 32'h000);
    wait_to(rel + 6530); chk("tp_x63",  32'(rgb_f()), 32'h000);
    wait_to(rel + 6532); chk("tp_x64",  32'(rgb_f()), 32'h00F);
    wait_to(rel + 7300); chk("tp_x448", 32'(rgb_f()), 32'hFFF);
    wait_to(rel + 7426); chk("tp_x511", 32'(rgb_f()), 32'hFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
